si5340_i2c_responder: RTL and testbench
=======================================

# si5340_i2c_responder

- I2C target (slave) that emulates the Si5340 register interface at 7-bit address 0x74.
- It is the far end of the config loader's I2C master: it decodes START, address, register-address and data bytes from SCL/SDA, and turns each written byte into a 16-bit {page, register} write strobe.
- It serves reads from an external register source.
- Used as a synthesizable loopback target in the FPGA test image and as the DUT-side model in loader simulations.

## Interface
- SLAVE_ADDR, 7'b111_0100, target address matched against the first byte after START.
- PAGE_REG, 8'h01, register address that updates the internal page register.
- clk_i  in  1  system clock (125 MHz nominal).
- rst_i  in  1  reset; synchronous and active-high.
- scl_i  in  1  raw SCL from pad, asynchronous.
- sda_i  in  1  raw SDA from pad, asynchronous.
- sda_oe_o  out  1  1 = pull SDA low (open-drain enable); 0 = release.
- wr_valid_o  out  1  one-cycle write strobe.
- wr_addr_o  out  16  {page, reg} of the write; valid with wr_valid_o.
- wr_data_o  out  8  write data; valid with wr_valid_o.
- rd_addr_o  out  16  {page, reg} of the byte about to be read.
- rd_data_i  in  8  read data; must be valid 1 clk after rd_addr_o changes.
- busy_o  out  1  high from an address-matched START until STOP.

## Operation
**Input sampling and bus events**
- SCL and SDA pass through 2-FF synchronizers, then one edge-detect register.
- START or repeated START: synchronized SDA falls while SCL is high. STOP: SDA rises while SCL is high.

**State machine:** IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- A 3-bit bit counter tracks each byte, MSB first. SDA is sampled on the SCL rising edge. sda_oe_o changes only on an SCL falling edge.
- DEV_ADDR → DEV_ACK on an address match.
  - R/W=0: DEV_ACK → REG_ADDR.
  - R/W=1: DEV_ACK → RD_DATA.
  - Mismatch: → IGNORE; sda_oe_o stays 0 until the next START/STOP.
- REG_ADDR → REG_ACK, which latches reg_ptr and then → WR_DATA.
- WR_DATA → WR_ACK, with a wr_valid_o pulse of {page, reg_ptr} and the data byte.
  - If reg_ptr == PAGE_REG, page takes the data byte.
  - reg_ptr then increments, wrapping 0xFF → 0x00; page is unaffected by the wrap.
  - WR_ACK → WR_DATA.
- RD_DATA shifts out the byte loaded from rd_data_i, then → RD_ACK.
  - Master ACK (SDA=0): reg_ptr increments and the FSM → RD_DATA.
  - Master NACK: → IGNORE until STOP or START.
- Any START → DEV_ADDR from any state. Any STOP → IDLE from any state, with sda_oe_o released.
- The page register persists across transactions. Only rst_i clears it.
- rst_i mid-transfer: every register returns to its reset value at the next clk; a partial byte is discarded, and no wr_valid_o is issued.

## Timing
**Reset values:** sda_oe_o=0, wr_valid_o=0, wr_addr_o=0, wr_data_o=0, rd_addr_o=0, busy_o=0, page=0, reg_ptr=0, state=IDLE.

**Event detection and ACK drive**
- Latency from a pad edge to the detected event is 3 clk.
- The ACK drive (sda_oe_o=1) asserts 1 clk after the SCL falling edge that ends bit 8 is detected.
- It releases 1 clk after the next detected SCL falling edge.

**Write path**
- wr_valid_o rises 1 clk after the detected SCL rising edge of data bit 8.
- wr_valid_o is exactly one cycle wide.
- wr_addr_o and wr_data_o hold their values until the next strobe.

**Read path**
- rd_addr_o updates on entry to RD_DATA.
- rd_data_i is captured into the transmit shifter 1 clk later, before the SCL falling edge that starts bit 7.
- Minimum supported SCL period: 16 clk (4 clk per phase).

## Configuration
- `SI5340_I2C_READ_EN` defined: the read path (RD_DATA/RD_ACK, transmit shifter, rd_addr_o driven) is present.
- Not defined:
  - An address byte with R/W=1 is NACKed (sda_oe_o stays 0) and the FSM → IGNORE.
  - rd_addr_o is tied to 0 and rd_data_i is unused.

## Structure
- In cfg_pkg: the state enum, the r_w enum (WRITE/READ), SLAVE_ADDR and DATA_WIDTH.
- One sub-module, `i2c_bus_sync`:
  - synchronizers plus edge detect;
  - outputs scl_rise, scl_fall, start_det, stop_det and sda_s.
- The FSM, shifters and page/pointer registers live in the top module.

## Test plan
- Write 0x74/W, reg 0x01, data 0x0B → ACK on all 3 bytes; page=0x0B; one wr_valid_o with addr 0x0001, data 0x0B.
- Then write reg 0x1F with data 0xAA, 0xBB → two strobes: {0x0B1F, 0xAA}, then {0x0B20, 0xBB}.
- Address 0x75/W → no ACK (SDA high in the 9th clock); no wr_valid_o; busy_o=0.
- Read 0x74/W reg 0x10, repeated START, 0x74/R with rd_data_i returning 0x5A then 0x5B; master ACKs, then NACKs → bytes 0x5A, 0x5B on SDA; rd_addr_o 0x0B10, then 0x0B11.
  - Without `SI5340_I2C_READ_EN` → address NACKed.
- Write reg 0xFF with data 0x01, 0x02 → strobes to 0x0BFF, then 0x0B00.
- rst_i asserted after 4 data bits of a byte → all outputs at reset values next clk; no strobe.
  - The following complete transaction succeeds.

Source files
------------

// File: rtl/cfg_pkg.sv
// Shared types and constants for the Si5340 I2C register-interface responder.
package cfg_pkg;

  localparam int         DATA_WIDTH = 8;
  localparam logic [6:0] SLAVE_ADDR = 7'b111_0100;
  localparam logic [7:0] PAGE_REG   = 8'h01;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_DEV_ACK,
    ST_REG_ADDR,
    ST_REG_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } state_e;

  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } r_w_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronizers for raw SCL/SDA plus one edge-detect stage that
// produces SCL edges and START/STOP bus conditions.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic scl_p0, scl_p1, scl_p2;
  logic sda_p0, sda_p1, sda_p2;

  // p0/p1 synchronize, p2 holds the previous synchronized level; idle bus is high
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_p0 <= 1'b1;
      scl_p1 <= 1'b1;
      scl_p2 <= 1'b1;
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
      sda_p2 <= 1'b1;
    end else begin
      scl_p0 <= scl;
      scl_p1 <= scl_p0;
      scl_p2 <= scl_p1;
      sda_p0 <= sda;
      sda_p1 <= sda_p0;
      sda_p2 <= sda_p1;
    end
  end

  assign sda_s     = sda_p1;
  assign scl_rise  = scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 & scl_p2;
  assign start_det = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
  assign stop_det  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;

endmodule

// File: rtl/si5340_i2c_responder.sv
// I2C target emulating the Si5340 paged register interface at address 0x74.
// Define SI5340_I2C_READ_EN to include the read path; otherwise reads are NACKed.
module si5340_i2c_responder
  import cfg_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe_o,
  output logic                  wr_valid_o,
  output logic [15:0]           wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic [15:0]           rd_addr_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  busy_o
);

`ifdef SI5340_I2C_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync u_sync (
    .clk       (clk_i),
    .rst       (rst_i),
    .scl       (scl_i),
    .sda       (sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  state_e                state, state_nxt;
  r_w_e                  rw;
  logic [2:0]            bit_cnt;
  logic [DATA_WIDTH-2:0] shift;
  logic [DATA_WIDTH-1:0] byte_in, page, reg_ptr, wr_data;
  logic [15:0]           wr_addr;
  logic                  wr_valid, sda_oe, busy, bit_last, addr_ok;

  assign byte_in  = {shift, sda_s};
  assign bit_last = (bit_cnt == 3'd7);
  assign addr_ok  = (byte_in[7:1] == SLAVE_ADDR) && ((byte_in[0] == 1'b0) || READ_EN);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // ACK states hand over on the rising SCL of the 9th clock so a read byte's
  // MSB can be driven on the very next falling edge.
  always_comb begin
    state_nxt = state;
    if (stop_det) begin
      state_nxt = ST_IDLE;
    end else if (start_det) begin
      state_nxt = ST_DEV_ADDR;
    end else begin
      case (state)
        ST_DEV_ADDR: if (scl_rise && bit_last) state_nxt = addr_ok ? ST_DEV_ACK : ST_IGNORE;
        ST_DEV_ACK:  if (scl_rise) state_nxt = (rw == READ) ? ST_RD_DATA : ST_REG_ADDR;
        ST_REG_ADDR: if (scl_rise && bit_last) state_nxt = ST_REG_ACK;
        ST_REG_ACK:  if (scl_rise) state_nxt = ST_WR_DATA;
        ST_WR_DATA:  if (scl_rise && bit_last) state_nxt = ST_WR_ACK;
        ST_WR_ACK:   if (scl_rise) state_nxt = ST_WR_DATA;
`ifdef SI5340_I2C_READ_EN
        ST_RD_DATA:  if (scl_rise && bit_last) state_nxt = ST_RD_ACK;
        ST_RD_ACK:   if (scl_rise) state_nxt = sda_s ? ST_IGNORE : ST_RD_DATA;
`endif
        default: ;
      endcase
    end
  end

`ifdef SI5340_I2C_READ_EN
  logic [15:0]           rd_addr;
  logic [DATA_WIDTH-1:0] tx;
  logic                  load_pend;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sda_oe   <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      page     <= '0;
      reg_ptr  <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      rw       <= WRITE;
`ifdef SI5340_I2C_READ_EN
      rd_addr   <= '0;
      tx        <= '0;
      load_pend <= 1'b0;
`endif
    end else begin
      wr_valid <= 1'b0;
`ifdef SI5340_I2C_READ_EN
      load_pend <= 1'b0;
      if (load_pend) tx <= rd_data_i;
`endif
      if (stop_det) begin
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        bit_cnt <= '0;
      end else if (start_det) begin
        sda_oe  <= 1'b0;
        bit_cnt <= '0;
      end else begin
        case (state)
          ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
            if (scl_fall) sda_oe <= 1'b0;
            if (scl_rise) begin
              shift   <= byte_in[DATA_WIDTH-2:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_last && state == ST_DEV_ADDR) begin
                rw <= r_w_e'(byte_in[0]);
                if (addr_ok) busy <= 1'b1;
              end
              if (bit_last && state == ST_REG_ADDR) reg_ptr <= byte_in;
              if (bit_last && state == ST_WR_DATA) begin
                wr_valid <= 1'b1;
                wr_addr  <= {page, reg_ptr};
                wr_data  <= byte_in;
                if (reg_ptr == PAGE_REG) page <= byte_in;
                reg_ptr  <= reg_ptr + 8'd1;
              end
            end
          end
          ST_DEV_ACK, ST_REG_ACK, ST_WR_ACK: begin
            if (scl_fall) sda_oe <= 1'b1;
            if (scl_rise) bit_cnt <= '0;
`ifdef SI5340_I2C_READ_EN
            if (scl_rise && state == ST_DEV_ACK && rw == READ) begin
              rd_addr   <= {page, reg_ptr};
              load_pend <= 1'b1;
            end
`endif
          end
`ifdef SI5340_I2C_READ_EN
          ST_RD_DATA: begin
            if (scl_fall) begin
              sda_oe <= ~tx[7];
              tx     <= {tx[6:0], 1'b0};
            end
            if (scl_rise) bit_cnt <= bit_cnt + 3'd1;
          end
          ST_RD_ACK: begin
            if (scl_fall) sda_oe <= 1'b0;
            if (scl_rise && !sda_s) begin
              reg_ptr   <= reg_ptr + 8'd1;
              rd_addr   <= {page, reg_ptr + 8'd1};
              load_pend <= 1'b1;
              bit_cnt   <= '0;
            end
          end
`endif
          default: sda_oe <= 1'b0;
        endcase
      end
    end
  end

  assign sda_oe_o   = sda_oe;
  assign wr_valid_o = wr_valid;
  assign wr_addr_o  = wr_addr;
  assign wr_data_o  = wr_data;
  assign busy_o     = busy;

`ifdef SI5340_I2C_READ_EN
  assign rd_addr_o = rd_addr;
`else
  logic unused_rd;
  assign unused_rd = ^rd_data_i;
  assign rd_addr_o = '0;
`endif

endmodule

// File: tb/tb_si5340_i2c_responder.sv
// Directed bench: bit-banged I2C master against the responder with an
// open-drain SDA model and a write-strobe recorder.
module tb_si5340_i2c_responder;

  localparam int Q = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_bus;
  logic        sda_oe, wr_valid, busy;
  logic [15:0] wr_addr, rd_addr;
  logic [7:0]  wr_data, rd_data;

  int checks = 0;
  int passes = 0;
  logic [23:0] strobes [$];

  always #5 clk = ~clk;

  assign sda_bus = sda_m & ~sda_oe;
  assign rd_data = (rd_addr == 16'h0B10) ? 8'h5A :
                   (rd_addr == 16'h0B11) ? 8'h5B : 8'hFF;

  si5340_i2c_responder dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .scl_i      (scl_m),
    .sda_i      (sda_bus),
    .sda_oe_o   (sda_oe),
    .wr_valid_o (wr_valid),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data),
    .rd_addr_o  (rd_addr),
    .rd_data_i  (rd_data),
    .busy_o     (busy)
  );

  always @(negedge clk) if (wr_valid) strobes.push_back({wr_addr, wr_data});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic check_strobe(input string tag, input int idx, input logic [23:0] exp);
    logic [23:0] obs;
    obs = (idx < strobes.size()) ? strobes[idx] : 24'hxxxxxx;
    check(tag, {8'h00, obs}, {8'h00, exp});
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    clks(Q); sda_m = 1'b1;
    clks(Q); scl_m = 1'b1;
    clks(Q); sda_m = 1'b0;
    clks(Q); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    clks(Q); sda_m = 1'b0;
    clks(Q); scl_m = 1'b1;
    clks(Q); sda_m = 1'b1;
    clks(Q);
  endtask

  task automatic wr_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      clks(Q); sda_m = b[i];
      clks(Q); scl_m = 1'b1;
      clks(2 * Q); scl_m = 1'b0;
    end
  endtask

  // ack returns the SDA level in the 9th clock: 0 = ACK, 1 = NACK
  task automatic wr_byte(input logic [7:0] b, output logic ack);
    wr_bits(b, 8);
    clks(Q); sda_m = 1'b1;
    clks(Q); scl_m = 1'b1;
    clks(Q); ack = sda_bus;
    clks(Q); scl_m = 1'b0;
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      clks(Q); sda_m = 1'b1;
      clks(Q); scl_m = 1'b1;
      clks(Q); b[i] = sda_bus;
      clks(Q); scl_m = 1'b0;
    end
    clks(Q); sda_m = nack;
    clks(Q); scl_m = 1'b1;
    clks(2 * Q); scl_m = 1'b0;
    clks(Q); sda_m = 1'b1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_sda_oe"},   {31'd0, sda_oe},   32'd0);
    check({pfx, "_wr_valid"}, {31'd0, wr_valid}, 32'd0);
    check({pfx, "_wr_addr"},  {16'd0, wr_addr},  32'd0);
    check({pfx, "_wr_data"},  {24'd0, wr_data},  32'd0);
    check({pfx, "_rd_addr"},  {16'd0, rd_addr},  32'd0);
    check({pfx, "_busy"},     {31'd0, busy},     32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] rb;

    rst = 1'b1;
    clks(4);
    check_reset_outputs("reset");
    rst = 1'b0;
    clks(4);

    // page register write: reg 0x01 <= 0x0B
    i2c_start();
    wr_byte(8'hE8, ack); check("t1_addr_ack", {31'd0, ack}, 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd1);
    wr_byte(8'h01, ack); check("t1_reg_ack", {31'd0, ack}, 32'd0);
    wr_byte(8'h0B, ack); check("t1_data_ack", {31'd0, ack}, 32'd0);
    i2c_stop();
    clks(4);
    check("t1_busy_after_stop", {31'd0, busy}, 32'd0);
    check("t1_strobe_count", strobes.size(), 32'd1);
    check_strobe("t1_strobe0", 0, {16'h0001, 8'h0B});

    // burst write with auto-increment under page 0x0B
    i2c_start();
    wr_byte(8'hE8, ack); check("t2_addr_ack", {31'd0, ack}, 32'd0);
    wr_byte(8'h1F, ack); check("t2_reg_ack", {31'd0, ack}, 32'd0);
    wr_byte(8'hAA, ack); check("t2_d0_ack", {31'd0, ack}, 32'd0);
    wr_byte(8'hBB, ack); check("t2_d1_ack", {31'd0, ack}, 32'd0);
    i2c_stop();
    clks(4);
    check("t2_strobe_count", strobes.size(), 32'd3);
    check_strobe("t2_strobe1", 1, {16'h0B1F, 8'hAA});
    check_strobe("t2_strobe2", 2, {16'h0B20, 8'hBB});

    // wrong device address is ignored
    i2c_start();
    wr_byte(8'hEA, ack); check("t3_addr_nack", {31'd0, ack}, 32'd1);
    check("t3_busy", {31'd0, busy}, 32'd0);
    wr_byte(8'h55, ack); check("t3_data_nack", {31'd0, ack}, 32'd1);
    i2c_stop();
    clks(4);
    check("t3_strobe_count", strobes.size(), 32'd3);

    // register read through repeated START
    i2c_start();
    wr_byte(8'hE8, ack); check("t4_addr_ack", {31'd0, ack}, 32'd0);
    wr_byte(8'h10, ack); check("t4_reg_ack", {31'd0, ack}, 32'd0);
    i2c_start();
    wr_byte(8'hE9, ack);
`ifdef SI5340_I2C_READ_EN
    check("t4_rd_addr_ack", {31'd0, ack}, 32'd0);
    check("t4_rd_addr0", {16'd0, rd_addr}, 32'h0B10);
    rd_byte(1'b0, rb); check("t4_rd_byte0", {24'd0, rb}, 32'h5A);
    check("t4_rd_addr1", {16'd0, rd_addr}, 32'h0B11);
    rd_byte(1'b1, rb); check("t4_rd_byte1", {24'd0, rb}, 32'h5B);
`else
    check("t4_rd_addr_nack", {31'd0, ack}, 32'd1);
    check("t4_rd_addr_tied", {16'd0, rd_addr}, 32'h0000);
    rb = 8'h00;
`endif
    i2c_stop();
    clks(4);
    check("t4_strobe_count", strobes.size(), 32'd3);

    // register pointer wraps 0xFF -> 0x00 without touching the page
    i2c_start();
    wr_byte(8'hE8, ack); check("t5_addr_ack", {31'd0, ack}, 32'd0);
    wr_byte(8'hFF, ack); check("t5_reg_ack", {31'd0, ack}, 32'd0);
    wr_byte(8'h01, ack); check("t5_d0_ack", {31'd0, ack}, 32'd0);
    wr_byte(8'h02, ack); check("t5_d1_ack", {31'd0, ack}, 32'd0);
    i2c_stop();
    clks(4);
    check("t5_strobe_count", strobes.size(), 32'd5);
    check_strobe("t5_strobe3", 3, {16'h0BFF, 8'h01});
    check_strobe("t5_strobe4", 4, {16'h0B00, 8'h02});

    // reset in the middle of a data byte
    i2c_start();
    wr_byte(8'hE8, ack); check("t6_addr_ack", {31'd0, ack}, 32'd0);
    wr_byte(8'h30, ack); check("t6_reg_ack", {31'd0, ack}, 32'd0);
    wr_bits(8'hC3, 4);
    rst = 1'b1;
    clks(1);
    check_reset_outputs("midrst");
    rst = 1'b0;
    i2c_stop();
    clks(4);
    check("t6_strobe_count", strobes.size(), 32'd5);

    // next transaction works, page back to 0
    i2c_start();
    wr_byte(8'hE8, ack); check("t7_addr_ack", {31'd0, ack}, 32'd0);
    wr_byte(8'h05, ack); check("t7_reg_ack", {31'd0, ack}, 32'd0);
    wr_byte(8'h77, ack); check("t7_data_ack", {31'd0, ack}, 32'd0);
    i2c_stop();
    clks(4);
    check("t7_strobe_count", strobes.size(), 32'd6);
    check_strobe("t7_strobe5", 5, {16'h0005, 8'h77});

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
